// File: rtl/led_palette_pwm_driver.sv
// PWM driver for palette LEDs. All channels share one prescaler and one 0..254 duty counter.
// Palette inputs are latched into shadow registers only at period boundaries.
module led_palette_pwm_driver #(
  parameter int parm_color_led_count = 4,
  parameter int parm_basic_led_count = 4,
  parameter int parm_FCLK            = 40_000_000,
  parameter int parm_pwm_tick_hz     = 255_000
) (
  input  logic                              i_clk,
  input  logic                              i_srst,
  input  logic [8*parm_color_led_count-1:0] i_color_led_red_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_green_value,
  input  logic [8*parm_color_led_count-1:0] i_color_led_blue_value,
  input  logic [8*parm_basic_led_count-1:0] i_basic_led_lumin_value,
  output logic [parm_color_led_count-1:0]   eo_color_led_red,
  output logic [parm_color_led_count-1:0]   eo_color_led_green,
  output logic [parm_color_led_count-1:0]   eo_color_led_blue,
  output logic [parm_basic_led_count-1:0]   eo_basic_led,
  output logic                              o_period_strobe
);

  localparam int CN = parm_color_led_count;
  localparam int BN = parm_basic_led_count;
  localparam int D  = parm_FCLK / parm_pwm_tick_hz;
  localparam int PW = (D > 1) ? $clog2(D) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(D - 1);

  if (D < 1) begin : g_bad_divider
    $error("led_palette_pwm_driver: parm_FCLK / parm_pwm_tick_hz must be at least 1");
  end

  logic [PW-1:0]   r_presc;
  logic [7:0]      r_duty;
  logic            r_strobe;
  logic [8*CN-1:0] r_red_sh;
  logic [8*CN-1:0] r_green_sh;
  logic [8*CN-1:0] r_blue_sh;
  logic [8*BN-1:0] r_lumin_sh;
  logic [CN-1:0]   r_red;
  logic [CN-1:0]   r_green;
  logic [CN-1:0]   r_blue;
  logic [BN-1:0]   r_basic;
  logic            w_tick;
  logic            w_boundary;

  assign w_tick     = (r_presc == PRESC_LAST);
  assign w_boundary = w_tick && (r_duty == 8'd254);

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_presc  <= '0;
      r_duty   <= '0;
      r_strobe <= 1'b0;
    end else begin
      r_presc  <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) begin
        r_duty <= (r_duty == 8'd254) ? 8'd0 : r_duty + 8'd1;
      end
      r_strobe <= w_boundary;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_red_sh   <= '0;
      r_green_sh <= '0;
      r_blue_sh  <= '0;
      r_lumin_sh <= '0;
    end else if (w_boundary) begin
      r_red_sh   <= i_color_led_red_value;
      r_green_sh <= i_color_led_green_value;
      r_blue_sh  <= i_color_led_blue_value;
      r_lumin_sh <= i_basic_led_lumin_value;
    end
  end

  // Counter never reaches 255, so a shadow of 255 keeps the pin high through the wrap.
  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
      r_basic <= '0;
    end else begin
      for (int n = 0; n < CN; n++) begin
        r_red[n]   <= (r_duty < r_red_sh[8*n +: 8]);
        r_green[n] <= (r_duty < r_green_sh[8*n +: 8]);
        r_blue[n]  <= (r_duty < r_blue_sh[8*n +: 8]);
      end
      for (int n = 0; n < BN; n++) begin
        r_basic[n] <= (r_duty < r_lumin_sh[8*n +: 8]);
      end
    end
  end

  assign eo_color_led_red   = r_red;
  assign eo_color_led_green = r_green;
  assign eo_color_led_blue  = r_blue;
  assign eo_basic_led       = r_basic;
  assign o_period_strobe    = r_strobe;

endmodule

// File: tb/tb_led_palette_pwm_driver.sv
// Scoreboard bench: dut0 runs D=10 (2550-cycle period) with randomized palettes,
// dut1 runs D=1 (255-cycle period) with fixed palette values.
module tb_led_palette_pwm_driver;

  localparam int D0   = 10;
  localparam int PER0 = 2550;
  localparam int PER1 = 255;
  localparam logic [7:0] K_R = 8'h80;
  localparam logic [7:0] K_G = 8'hFF;
  localparam logic [7:0] K_B = 8'h00;
  localparam logic [7:0] K_L = 8'h01;

  typedef struct {
    int r;
    int g;
    int b;
    int l;
  } duty_t;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic [7:0] r_in = 8'h00;
  logic [7:0] g_in = 8'hFF;
  logic [7:0] b_in = 8'h80;
  logic [7:0] l_in = 8'h01;
  logic [7:0] k_r = K_R;
  logic [7:0] k_g = K_G;
  logic [7:0] k_b = K_B;
  logic [7:0] k_l = K_L;

  logic [0:0] red0, green0, blue0, bas0;
  logic [0:0] red1, green1, blue1, bas1;
  logic       strobe0, strobe1;
  logic [3:0] pins0;
  logic [3:0] pins1;

  assign pins0 = {bas0, blue0, green0, red0};
  assign pins1 = {bas1, blue1, green1, red1};

  always #5 clk = ~clk;

  led_palette_pwm_driver #(
    .parm_color_led_count(1), .parm_basic_led_count(1),
    .parm_FCLK(2550), .parm_pwm_tick_hz(255)
  ) dut0 (
    .i_clk(clk), .i_srst(srst),
    .i_color_led_red_value(r_in), .i_color_led_green_value(g_in),
    .i_color_led_blue_value(b_in), .i_basic_led_lumin_value(l_in),
    .eo_color_led_red(red0), .eo_color_led_green(green0),
    .eo_color_led_blue(blue0), .eo_basic_led(bas0),
    .o_period_strobe(strobe0)
  );

  led_palette_pwm_driver #(
    .parm_color_led_count(1), .parm_basic_led_count(1),
    .parm_FCLK(2550), .parm_pwm_tick_hz(2550)
  ) dut1 (
    .i_clk(clk), .i_srst(srst),
    .i_color_led_red_value(k_r), .i_color_led_green_value(k_g),
    .i_color_led_blue_value(k_b), .i_basic_led_lumin_value(k_l),
    .eo_color_led_red(red1), .eo_color_led_green(green1),
    .eo_color_led_blue(blue1), .eo_basic_led(bas1),
    .o_period_strobe(strobe1)
  );

  int    errors = 0;
  int    checks = 0;
  duty_t exp_q[$];
  string nm[4] = '{"red", "green", "blue", "basic"};

  function automatic void check(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endfunction

  // Bench time base: edges since the last edge that sampled reset high.
  int rel_cyc = 0;
  always @(posedge clk) begin
    if (srst) rel_cyc <= 0;
    else      rel_cyc <= rel_cyc + 1;
  end

  // Monitor for dut0: a window is the 2550 samples after a strobe up to and
  // including the next strobe; sample i is high iff i <= duty*D.
  bit skip0 = 1'b0;
  bit have0 = 1'b0;
  int smp0 = 0;
  int win_done = 0;
  int cur_v[4];
  int mis0[4];

  function automatic void open_win0();
    duty_t e;
    if (exp_q.size() == 0) begin
      have0 = 1'b0;
    end else begin
      e = exp_q.pop_front();
      cur_v[0] = e.r;
      cur_v[1] = e.g;
      cur_v[2] = e.b;
      cur_v[3] = e.l;
      have0 = 1'b1;
    end
    smp0 = 0;
    for (int c = 0; c < 4; c++) mis0[c] = 0;
  endfunction

  always @(negedge clk) begin
    if (srst) begin
      exp_q.delete();
      skip0 = 1'b1;
      have0 = 1'b0;
      smp0  = 0;
    end else if (skip0) begin
      skip0 = 1'b0;
      check("pins_low_after_reset_edge",
            int'({pins0, strobe0, pins1, strobe1}), 0);
      open_win0();
    end else begin
      smp0++;
      for (int c = 0; c < 4; c++) begin
        if (pins0[c] !== (have0 && (smp0 <= cur_v[c] * D0))) mis0[c]++;
      end
      if (strobe0) begin
        if (!have0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window: actual=strobe after %0d cycles required=no window", smp0);
        end else begin
          check("period_len_d10", smp0, PER0);
          for (int c = 0; c < 4; c++)
            check($sformatf("%s_sample_mismatches_duty%0d", nm[c], cur_v[c]), mis0[c], 0);
          win_done++;
        end
        open_win0();
      end
    end
  end

  // Monitor for dut1 (D=1): first window after reset is all low, later ones
  // give duty high cycles per 255.
  bit skip1 = 1'b0;
  bit first1 = 1'b0;
  int smp1 = 0;
  int hi1[4];

  always @(negedge clk) begin
    if (srst) begin
      skip1  = 1'b1;
      first1 = 1'b1;
    end else if (skip1) begin
      skip1 = 1'b0;
      smp1  = 0;
      for (int c = 0; c < 4; c++) hi1[c] = 0;
    end else begin
      smp1++;
      for (int c = 0; c < 4; c++) hi1[c] += int'(pins1[c]);
      if (strobe1) begin
        check("period_len_d1", smp1, PER1);
        check("d1_red_high",   hi1[0], first1 ? 0 : int'(K_R));
        check("d1_green_high", hi1[1], first1 ? 0 : int'(K_G));
        check("d1_blue_high",  hi1[2], first1 ? 0 : int'(K_B));
        check("d1_basic_high", hi1[3], first1 ? 0 : int'(K_L));
        first1 = 1'b0;
        smp1   = 0;
        for (int c = 0; c < 4; c++) hi1[c] = 0;
      end
    end
  end

  task automatic wait_to(input int c);
    int guard = 0;
    while (rel_cyc < c) begin
      @(posedge clk);
      #1;
      guard++;
      if (guard > 60000) begin
        $display("FAIL wait_timeout: actual=%0d required=%0d", rel_cyc, c);
        $fatal(1, "time base stalled");
      end
    end
  endtask

  function automatic void push_inputs();
    duty_t e;
    e.r = int'(r_in);
    e.g = int'(g_in);
    e.b = int'(b_in);
    e.l = int'(l_in);
    exp_q.push_back(e);
  endfunction

  function automatic void push_zero();
    duty_t e;
    e.r = 0;
    e.g = 0;
    e.b = 0;
    e.l = 0;
    exp_q.push_back(e);
  endfunction

  int sweep[5] = '{0, 1, 127, 254, 255};
  int v[4];

  initial begin
    repeat (3) @(posedge clk);
    #1;
    srst = 1'b0;
    push_zero();
    push_inputs();

    // Mid-period change only shows up from the next period.
    wait_to(PER0 + 500);
    b_in = 8'h10;
    push_inputs();

    for (int p = 3; p <= 13; p++) begin
      wait_to(PER0 * (p - 1) + 300);
      r_in = 8'($urandom_range(0, 255));
      g_in = 8'($urandom_range(0, 255));
      b_in = 8'($urandom_range(0, 255));
      l_in = 8'($urandom_range(0, 255));
      wait_to(PER0 * (p - 1) + 1500);
      for (int c = 0; c < 4; c++) begin
        if (p <= 7) v[c] = sweep[(p - 3 + c) % 5];
        else        v[c] = int'($urandom_range(0, 255));
      end
      if (p == 13) v[1] = 255;
      r_in = 8'(v[0]);
      g_in = 8'(v[1]);
      b_in = 8'(v[2]);
      l_in = 8'(v[3]);
      push_inputs();
    end

    // One-cycle reset in the middle of a period with green fully on.
    wait_to(PER0 * 13 + 1000);
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    push_zero();
    push_inputs();

    wait_to(PER0 * 2 + 5);
    check("leftover_expected", exp_q.size(), 0);
    check("windows_checked", win_done, 15);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_palette_pwm_driver.md
Name: led_palette_pwm_driver

Overview:
Receiving end of the LED palette interface. Consumes packed 8-bit-per-channel palette values (red, green and blue per color LED; luminance per basic LED) from the palette pulser and drives the board LED pins with fixed-frequency PWM. Palette values are double-buffered and take effect only at PWM period boundaries, so the LEDs never glitch. Sits between the palette pulser and the top-level LED pins.

Parameters:
parm_color_led_count, 4, number of RGB LEDs
parm_basic_led_count, 4, number of single-color LEDs
parm_FCLK, 40_000_000, i_clk frequency in Hz
parm_pwm_tick_hz, 255_000, PWM step rate; the PWM period is 255 ticks (default about 1 kHz)

Ports:
i_clk  in  1  system clock
i_srst  in  1  synchronous active-high reset
i_color_led_red_value  in  8*parm_color_led_count  red duty; LED n uses bits [8n+7:8n]
i_color_led_green_value  in  8*parm_color_led_count  green duty, same packing
i_color_led_blue_value  in  8*parm_color_led_count  blue duty, same packing
i_basic_led_lumin_value  in  8*parm_basic_led_count  basic LED duty, same packing
eo_color_led_red  out  parm_color_led_count  red PWM pins
eo_color_led_green  out  parm_color_led_count  green PWM pins
eo_color_led_blue  out  parm_color_led_count  blue PWM pins
eo_basic_led  out  parm_basic_led_count  basic LED PWM pins
o_period_strobe  out  1  one-cycle pulse marking the start of each PWM period

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high on i_srst.
- Reset values: all eo_* = 0, o_period_strobe = 0, prescaler = 0, duty counter = 0, all shadow registers = 0.
- Prescaler:
  - D = parm_FCLK / parm_pwm_tick_hz (integer truncation). Elaboration error if D < 1.
  - The counter runs 0..D-1. The internal tick is high for exactly one cycle when the count is D-1, and the count then wraps to 0.
  - D = 1 gives a tick every cycle.
- Duty counter: 8 bits, range 0..254. Advances by 1 on each tick; on a tick at 254 it wraps to 0. It never holds 255.
- Period boundary = the tick on which the duty counter wraps 254 -> 0. On that same clock edge:
  - every shadow register loads its input slice;
  - o_period_strobe is registered high for the following cycle only.
- Compare: each output is registered as (duty counter < shadow value).
  - One cycle of latency from a counter change to the pin.
  - Duty value v gives v high ticks out of 255.
  - v = 0: pin constantly low.
  - v = 255: pin constantly high, with no single-tick dropout.
  - v = 1: high for exactly one tick (D cycles) per period.
- Input changes mid-period are ignored until the next boundary. Inputs held stable across a boundary are captured exactly; no handshake is required.
- First period after reset: shadows are 0, so all pins stay low. The first capture happens at the first boundary, which falls 255*D cycles after reset release.
- Reset asserted mid-period: on the next edge all state returns to its reset values and pins go low immediately.
- All color and basic channels share one duty counter, so all PWM edges are phase-aligned.

Test Plan (parm_FCLK=2550, parm_pwm_tick_hz=255, so D=10 and the period is 2550 cycles; 1 color LED, 1 basic LED):
1. Reset, then drive red=8'h00, green=8'hFF, blue=8'h80, basic=8'h01 and wait one full period. Required: from the second period on, red is always 0, green is always 1, blue is high for 1280 consecutive cycles of every 2550, and basic is high for 10 cycles per period.
2. Measure o_period_strobe. Required: exactly one-cycle pulses 2550 cycles apart; the first occurs at cycle 2551 after reset release; every pin rises in the cycle after a strobe when its duty is non-zero.
3. Change blue 8'h80 -> 8'h10 at cycle 500 of a period. Required: the current period still gives 1280 high cycles; the next period gives 160.
4. Assert i_srst for 1 cycle mid-period while green=8'hFF. Required: all pins read 0 on the cycle after the reset edge, and green stays low for a full 2550-cycle period (shadows cleared).
5. Sweep the duty over 0, 1, 127, 254, 255. Required: high-cycle counts per period are 0, 10, 1270, 2540, 2550.
6. Set D=1 (parm_pwm_tick_hz=2550). Required: period = 255 cycles and duty 8'h80 gives 128 high cycles.
